// File: rtl/gpio_mmio_port_if.sv
// Data-bus port of the GPIO responder: one-cycle access strobe in,
// registered acknowledge and read data out.
interface gpio_mmio_port_if;
   logic        sel;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output sel, we, addr, wdata, input rdata, ready);
   modport slave  (input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/gpio_mmio_port.sv
// Memory-mapped GPIO responder: synchronised and debounced inputs, LED output
// register, sticky rising-edge flags with a maskable interrupt.
module gpio_mmio_port #(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = 4,
   parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
   input  logic             clk,
   input  logic             reset,
   gpio_mmio_port_if.slave  bus,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic             irq
);
   localparam logic [7:0] CNT_LAST    = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] REG_DATA_IN = 2'd0;
   localparam logic [1:0] REG_DATA_OUT = 2'd1;
   localparam logic [1:0] REG_EDGE    = 2'd2;
   localparam logic [1:0] REG_EDGE_EN = 2'd3;

   logic [WIDTH-1:0] s1_reg, s2_reg, cand_reg, stable_reg;
   logic [7:0]       cnt_reg;
   logic [WIDTH-1:0] data_out_reg, edge_reg, edge_en_reg;
   logic [31:0]      rdata_reg;
   logic             ready_reg;

   logic             commit;
   logic             wr_en;
   logic [1:0]       reg_sel;
   logic [WIDTH-1:0] edge_set, edge_clr, edge_next, rd_value;
   logic             bus_unused;

   assign reg_sel  = bus.addr[3:2];
   assign wr_en    = bus.sel & bus.we;
   // The candidate is committed every cycle once it has been stable long enough.
   assign commit   = (s2_reg == cand_reg) && (cnt_reg == CNT_LAST);
   assign edge_set = commit ? (cand_reg & ~stable_reg) : '0;
   assign edge_clr = (wr_en && reg_sel == REG_EDGE) ? bus.wdata[WIDTH-1:0] : '0;

   // A commit landing on the same edge as a W1C keeps the flag set.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_next[gi] = edge_set[gi] | (edge_reg[gi] & ~edge_clr[gi]);
   end

   always_comb begin
      rd_value = stable_reg;
      case (reg_sel)
         REG_DATA_IN:  rd_value = stable_reg;
         REG_DATA_OUT: rd_value = data_out_reg;
         REG_EDGE:     rd_value = edge_reg;
         REG_EDGE_EN:  rd_value = edge_en_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_reg       <= '0;
         s2_reg       <= '0;
         cand_reg     <= '0;
         stable_reg   <= '0;
         cnt_reg      <= '0;
         data_out_reg <= OUT_RESET;
         edge_reg     <= '0;
         edge_en_reg  <= '0;
         rdata_reg    <= '0;
         ready_reg    <= 1'b0;
      end else begin
         s1_reg <= gpio_in;
         s2_reg <= s1_reg;

         if (s2_reg != cand_reg) begin
            cand_reg <= s2_reg;
            cnt_reg  <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= cand_reg;
         end else begin
            cnt_reg <= cnt_reg + 8'd1;
         end

         edge_reg  <= edge_next;
         ready_reg <= bus.sel;

         if (bus.sel && !bus.we) begin
            rdata_reg <= 32'(rd_value);
         end

         if (wr_en && reg_sel == REG_DATA_OUT) begin
            data_out_reg <= bus.wdata[WIDTH-1:0];
         end
         if (wr_en && reg_sel == REG_EDGE_EN) begin
            edge_en_reg <= bus.wdata[WIDTH-1:0];
         end
      end
   end

   assign bus_unused = ^{bus.wdata, bus.addr[1:0]};

   assign gpio_out  = data_out_reg;
   assign irq       = |(edge_reg & edge_en_reg);
   assign bus.rdata = rdata_reg;
   assign bus.ready = ready_reg;
endmodule

// File: tb/tb_gpio_mmio_port.sv
// Directed plus randomized bench for gpio_mmio_port against a cycle-level
// reference model built from pin-sample history.
module tb_gpio_mmio_port;
   localparam int         DB      = 4;
   localparam int         HIST    = DB + 3;
   localparam logic [7:0] OUT_RST = 8'h00;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] gpio_in = 8'h00;
   logic [7:0] gpio_out;
   logic       irq;

   gpio_mmio_port_if bus_if ();

   gpio_mmio_port #(
      .WIDTH(8),
      .DEBOUNCE_CYCLES(DB),
      .OUT_RESET(OUT_RST)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus_if.slave),
      .gpio_in(gpio_in),
      .gpio_out(gpio_out),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: index 0 is the pin value sampled at the newest edge.
   logic [7:0]  pin_hist[$];
   logic [7:0]  stable_m, data_out_m, edge_m, en_m;
   logic [31:0] rdata_m;
   logic        ready_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      pin_hist.delete();
      for (int k = 0; k < HIST; k++) pin_hist.push_back(8'h00);
      stable_m   = 8'h00;
      data_out_m = OUT_RST;
      edge_m     = 8'h00;
      en_m       = 8'h00;
      rdata_m    = 32'h0;
      ready_m    = 1'b0;
   endfunction

   function automatic logic [7:0] model_reg(input logic [1:0] idx);
      case (idx)
         2'd0:    return stable_m;
         2'd1:    return data_out_m;
         2'd2:    return edge_m;
         default: return en_m;
      endcase
   endfunction

   // One clock: update the model from the pre-edge inputs, then compare outputs.
   task automatic step();
      logic [7:0] x, set_v, clr_v;
      logic [1:0] idx;
      bit         commit;
      @(posedge clk);
      idx = bus_if.addr[3:2];
      pin_hist.push_front(gpio_in);
      void'(pin_hist.pop_back());
      // A value commits once DB+1 consecutive synchronised samples agree.
      x = pin_hist[2];
      commit = 1'b1;
      for (int k = 2; k < HIST; k++) if (pin_hist[k] !== x) commit = 1'b0;
      set_v = commit ? (x & ~stable_m) : 8'h00;
      clr_v = (bus_if.sel && bus_if.we && idx == 2'd2) ? bus_if.wdata[7:0] : 8'h00;
      ready_m = bus_if.sel;
      if (bus_if.sel && !bus_if.we) rdata_m = {24'h0, model_reg(idx)};
      if (bus_if.sel && bus_if.we && idx == 2'd1) data_out_m = bus_if.wdata[7:0];
      if (bus_if.sel && bus_if.we && idx == 2'd3) en_m = bus_if.wdata[7:0];
      edge_m = (edge_m & ~clr_v) | set_v;
      if (commit) stable_m = x;
      #1;
      check("gpio_out", gpio_out, data_out_m);
      check("irq", irq, |(edge_m & en_m));
      check("ready", bus_if.ready, ready_m);
      check("rdata", bus_if.rdata, rdata_m);
   endtask

   task automatic drive(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
      bus_if.sel   = s;
      bus_if.we    = w;
      bus_if.addr  = a;
      bus_if.wdata = d;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 1'b0, 4'h0, 32'h0);
      repeat (n) step();
   endtask

   task automatic write(input logic [3:0] a, input logic [31:0] d);
      drive(1'b1, 1'b1, a, d);
      step();
      drive(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic read(input logic [3:0] a);
      drive(1'b1, 1'b0, a, 32'h0);
      step();
      drive(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   task automatic apply_reset();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check("rst_gpio_out", gpio_out, OUT_RST);
      check("rst_irq", irq, 1'b0);
      check("rst_ready", bus_if.ready, 1'b0);
      check("rst_rdata", bus_if.rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      drive(1'b0, 1'b0, 4'h0, 32'h0);
      model_reset();
      apply_reset();
      idle(5);

      // LED register write then read-back
      write(4'h4, 32'h0000_00A5);
      check("wr_gpio_out", gpio_out, 8'hA5);
      check("wr_ready", bus_if.ready, 1'b1);
      read(4'h4);
      check("rd_data_out", bus_if.rdata, 32'h0000_00A5);
      idle(2);

      // Short glitch must not commit; a long hold must
      gpio_in = 8'h01;
      idle(3);
      gpio_in = 8'h00;
      idle(10);
      read(4'h0);
      check("glitch_data_in", bus_if.rdata, 32'h0);
      read(4'h8);
      check("glitch_edge", bus_if.rdata, 32'h0);
      gpio_in = 8'h01;
      idle(10);
      read(4'h0);
      check("hold_data_in", bus_if.rdata, 32'h1);
      read(4'h8);
      check("hold_edge", bus_if.rdata, 32'h1);

      // Interrupt mask and W1C
      write(4'h8, 32'hFF);
      gpio_in = 8'h00;
      idle(10);
      write(4'hC, 32'h01);
      gpio_in = 8'h01;
      idle(10);
      check("irq_set", irq, 1'b1);
      write(4'h8, 32'h01);
      check("irq_clr", irq, 1'b0);
      gpio_in = 8'h03;
      idle(10);
      check("irq_masked", irq, 1'b0);
      read(4'h8);
      check("edge_bit1", bus_if.rdata, 32'h2);

      // W1C on the same edge as a bit0 commit
      write(4'h8, 32'hFF);
      gpio_in = 8'h02;
      idle(10);
      gpio_in = 8'h03;
      idle(6);
      write(4'h8, 32'h01);
      read(4'h8);
      check("collision_edge", bus_if.rdata, 32'h1);
      check("collision_irq", irq, 1'b1);

      // Pins held high through reset commit as a rising edge
      gpio_in = 8'hFF;
      apply_reset();
      idle(7);
      drive(1'b1, 1'b0, 4'h0, 32'h0);
      step();
      check("b2b_data_in", bus_if.rdata, 32'hFF);
      check("b2b_ready0", bus_if.ready, 1'b1);
      drive(1'b1, 1'b0, 4'h8, 32'h0);
      step();
      check("b2b_edge", bus_if.rdata, 32'hFF);
      check("b2b_ready1", bus_if.ready, 1'b1);
      drive(1'b1, 1'b0, 4'hC, 32'h0);
      step();
      check("b2b_edge_en", bus_if.rdata, 32'h0);
      check("b2b_ready2", bus_if.ready, 1'b1);
      drive(1'b1, 1'b0, 4'h4, 32'h0);
      step();
      check("b2b_data_out", bus_if.rdata, {24'h0, OUT_RST});
      check("b2b_ready3", bus_if.ready, 1'b1);
      idle(1);
      check("b2b_ready_end", bus_if.ready, 1'b0);

      // Randomized traffic on pins and bus
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            drive(1'b0, 1'b0, 4'h0, 32'h0);
            apply_reset();
         end
         if ($urandom_range(0, 9) == 0) begin
            gpio_in = 8'($urandom);
         end else if ($urandom_range(0, 19) == 0) begin
            int b;
            b = $urandom_range(0, 7);
            gpio_in[b] = ~gpio_in[b];
         end
         if ($urandom_range(0, 1) == 1)
            drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
         else
            drive(1'b0, 1'b0, 4'h0, 32'h0);
         step();
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
